// File: rtl/hyperbus_rx_packer.sv
// rtl/hyperbus_rx_packer.sv - RWDS-domain DDR sample packer feeding the read CDC FIFO source side
module hyperbus_rx_packer #(
    parameter int DQ_WIDTH  = 8,
    parameter int PACK      = 2,
    parameter int CNT_WIDTH = 16
) (
    input  logic                       clk_rwds,
    input  logic                       resetReadModule,
    input  logic [CNT_WIDTH-1:0]       burst_len_i,
    input  logic [2*DQ_WIDTH-1:0]      sample_i,
    output logic                       out_valid_o,
    output logic [PACK*2*DQ_WIDTH-1:0] out_data_o,
    output logic [PACK-1:0]            out_strb_o,
    output logic                       out_last_o,
    input  logic                       out_ready_i,
    output logic                       overflow_o,
    output logic                       done_o
);

    localparam int SW    = 2 * DQ_WIDTH;
    localparam int W     = PACK * SW;
    localparam int IDX_W = (PACK > 1) ? $clog2(PACK) : 1;

    typedef enum logic [1:0] {
        ARM  = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [IDX_W-1:0]     idx_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_inc;
    logic [W-1:0]         asm_q;
    logic [W-1:0]         asm_word;
    logic [PACK-1:0]      strb_word;
    logic                 accept;
    logic                 final_sample;
    logic                 word_done;

    // Only RUN consumes samples; ARM swallows the unprimed first edge, DONE ignores trailing edges.
    assign accept       = (state_q == RUN);
    assign cnt_inc      = cnt_q + CNT_WIDTH'(1);
    assign final_sample = accept && (burst_len_i != '0) && (cnt_inc == burst_len_i);
    assign word_done    = accept && ((idx_q == IDX_W'(PACK - 1)) || final_sample);
    assign done_o       = (state_q == DONE) && !out_valid_o;

    // Burst phase register.
    always_ff @(posedge clk_rwds or posedge resetReadModule) begin
        if (resetReadModule) begin
            state_q <= ARM;
        end else begin
            state_q <= state_d;
        end
    end

    // Burst phase sequencing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARM:     state_d = RUN;
            RUN:     if (final_sample) state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = ARM;
        endcase
    end

    // Word being completed this edge: held lanes plus the incoming sample, and the lanes it fills.
    always_comb begin
        asm_word = asm_q;
        asm_word[idx_q*SW +: SW] = sample_i;
        strb_word = '0;
        for (int i = 0; i < PACK; i++) begin
            strb_word[i] = (i <= int'(idx_q));
        end
    end

    // Lane index, sample counter and assembly register; assembly clears on completion so a short tail is zero-padded.
    always_ff @(posedge clk_rwds or posedge resetReadModule) begin
        if (resetReadModule) begin
            idx_q <= '0;
            cnt_q <= '0;
            asm_q <= '0;
        end else if (accept) begin
            cnt_q <= cnt_inc;
            if (word_done) begin
                idx_q <= '0;
                asm_q <= '0;
            end else begin
                idx_q <= idx_q + IDX_W'(1);
                asm_q <= asm_word;
            end
        end
    end

    // Output register: a completed word loads if the slot is free or being pushed, otherwise it is lost and flagged.
    always_ff @(posedge clk_rwds or posedge resetReadModule) begin
        if (resetReadModule) begin
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_strb_o  <= '0;
            out_last_o  <= 1'b0;
            overflow_o  <= 1'b0;
        end else if (word_done) begin
            if (!out_valid_o || out_ready_i) begin
                out_valid_o <= 1'b1;
                out_data_o  <= asm_word;
                out_strb_o  <= strb_word;
                out_last_o  <= final_sample;
            end else begin
                overflow_o <= 1'b1;
                // RWDS cannot stall, so the held word must carry end-of-burst or the reader never terminates.
                if (final_sample) begin
                    out_last_o <= 1'b1;
                end
            end
        end else if (out_valid_o && out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end

endmodule

// File: doc/hyperbus_rx_packer.md
# hyperbus_rx_packer

RWDS-domain receive packer for the HyperBus PHY read path, parametrised in DQ width and output packing factor. It sits between the per-bit DDR input cells and the source side of the read CDC FIFO. It assembles consecutive DDR samples into wide words, tags the final word of a burst, handles FIFO back-pressure, and flags any data lost to back-pressure, because the RWDS clock cannot be stalled.

## Interface
Parameters:
- DQ_WIDTH, 8: DQ lanes per edge; legal values 8 or 16. One sample is 2*DQ_WIDTH bits.
- PACK, 2: samples per output word; legal values 1..8. Output word is W = PACK*2*DQ_WIDTH bits.
- CNT_WIDTH, 16: width of the burst-length counter.

Ports:
- clk_rwds  in  1  gated, delayed RWDS clock; all state updates on its rising edge.
- resetReadModule  in  1  asynchronous, active-high reset; asserted between bursts.
- burst_len_i  in  CNT_WIDTH  samples expected in this burst; 0 means unbounded. Must be stable while resetReadModule is low.
- sample_i  in  2*DQ_WIDTH  DDR sample from the input cells; falling-edge lanes in the upper half.
- out_valid_o  out  1  output word valid.
- out_data_o  out  W  packed word; the first sample occupies bits [2*DQ_WIDTH-1:0].
- out_strb_o  out  PACK  per-sample valid mask for out_data_o.
- out_last_o  out  1  word contains the final sample of the burst.
- out_ready_i  in  1  FIFO source ready.
- overflow_o  out  1  sticky: at least one word was dropped.
- done_o  out  1  burst complete; all words handed over.

## Operation
State machine, states ARM, RUN, DONE:
- ARM: reset state. The first rising edge is discarded (the DDR cells are not yet primed). Transition to RUN.
- RUN: every rising edge accepts sample_i.
  - The sample goes into lane idx of the assembly register; idx counts 0..PACK-1 and wraps to 0.
  - The accepted-sample counter cnt increments on each accepted sample.
  - A word completes when idx == PACK-1, or when cnt+1 == burst_len_i (burst_len_i != 0).
  - On completion, the assembly register, strobe and last flag are copied into the output register.
  - The assembly register is cleared to zero, so a partial final word is zero-padded and its unused lanes are 0 in out_strb_o.
- RUN to DONE: on the edge that accepts the final sample.
- DONE: further edges accept nothing; cnt is held. done_o = 1 once out_valid_o is 0.

Output register:
- Push occurs on an edge with out_valid_o && out_ready_i; out_valid_o then drops, unless a new word completes on the same edge, in which case the new word is loaded and out_valid_o stays 1.
- If a word completes while out_valid_o && !out_ready_i:
  - The new word is dropped and the held word is kept.
  - overflow_o is set and stays set until reset.
  - If the dropped word carried last, out_last_o is still forced to 1 on the held word, so the burst terminates.

Width rules:
- cnt is CNT_WIDTH bits and does not wrap in bounded mode.
- In unbounded mode cnt wraps silently and out_last_o never asserts.

## Timing
Reset values (resetReadModule high, asynchronous):
- state ARM, idx 0, cnt 0, assembly register 0.
- out_valid_o 0, out_data_o 0, out_strb_o 0, out_last_o 0, overflow_o 0, done_o 0.

Latency:
- A word whose final sample is accepted on edge k shows out_valid_o = 1 after edge k.
- Its push can occur no earlier than edge k+1.

Integrator requirement:
- RWDS keeps one trailing edge after the final sample (read clock enable is held one cycle longer) so the last word is pushed.
- A word still held when reset asserts is lost; done_o is never asserted in that case.

Reset mid-burst:
- All state clears immediately, independent of clk_rwds.
- The next burst starts in ARM.

Throughput:
- With out_ready_i continuously 1 and PACK >= 2, there is no overflow.
- With PACK = 1, sustained throughput needs out_ready_i = 1 on every edge.

## Test plan
- DQ_WIDTH=8, PACK=2, burst_len=4, samples 0x1111, 0x2222, 0x3333, 0x4444, ready=1. Required: two words, 0x22221111 (strb 11, last 0) and 0x44443333 (strb 11, last 1); done_o=1 after the trailing edge; overflow_o=0.
- PACK=4, burst_len=5, ready=1. Required: second word has strb 0001, data zero-padded above the 5th sample, last=1.
- PACK=2, ready held 0 across two completed words. Required: the first word is held unchanged, the second is dropped, overflow_o=1 until reset.
- DQ_WIDTH=16, PACK=1, burst_len=0, 10 edges after ARM. Required: 10 words of 32 bits; out_last_o never 1; done_o=0.
- Reset asserted mid-burst after 3 samples, released, then a new burst_len=2. Required: outputs clear asynchronously; the first edge after release is discarded; exactly one word with last=1.
- Word completes on the same edge as a push (ready=1, PACK=1). Required: out_valid_o stays 1; data updates each edge; no overflow.
